cpu_host_ctrl: RTL

Host-side job controller for the 8-bit CPU core. It is the initiator end of the core's `req`/`done` handshake and owns the data-memory port while the core is idle. For each job it streams operands into data memory, issues `req`, and waits for `done` under a cycle timeout. It then reads a fixed result window back out of data memory as a valid/ready stream.

---
 rtl/cpu_host_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cpu_host_ctrl.sv
// Host-side job controller for the 8-bit CPU core: loads operands into data memory,
// hands the job to the core with a req/done handshake, then streams the result window out.
module cpu_host_ctrl #(
    parameter logic [7:0] LD_BASE = 8'd0,
    parameter int         LD_LEN  = 8,
    parameter logic [7:0] RD_BASE = 8'd64,
    parameter int         RD_LEN  = 4,
    parameter int         TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    output logic       ld_ready,
    output logic       mem_sel,
    output logic       mem_wr_en,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wr_dat,
    input  logic [7:0] mem_rd_dat,
    output logic       cpu_req,
    input  logic       cpu_done,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       rd_ready,
    output logic       busy,
    output logic       job_done,
    output logic       timeout_err
);

    localparam int TW = $clog2(TIMEOUT);

    localparam logic [8:0]    LD_LAST  = 9'(LD_LEN - 1);
    localparam logic [8:0]    RD_LAST  = 9'(RD_LEN - 1);
    localparam logic [TW-1:0] RUN_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]    state;
    logic [8:0]    cnt;
    logic [TW-1:0] run_cnt;
    logic          armed;
    logic          timeout_flag;
    logic [7:0]    ld_addr;
    logic [7:0]    rd_addr;

    assign ld_addr = LD_BASE + cnt[7:0];
    assign rd_addr = RD_BASE + cnt[7:0];

    // The byte counter is shared by LOAD and DRAIN; it is cleared on every phase entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            run_cnt      <= '0;
            armed        <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_LOAD;
                        cnt          <= '0;
                        timeout_flag <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        if (cnt == LD_LAST) begin
                            state <= S_REQ;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 9'd1;
                        end
                    end
                end
                S_REQ: begin
                    state   <= S_RUN;
                    run_cnt <= '0;
                    armed   <= 1'b0;
                end
                S_RUN: begin
                    // Completion only counts once done has been seen low in this job.
                    if (armed && cpu_done) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                    end else if (run_cnt == RUN_LAST) begin
                        state        <= S_IDLE;
                        timeout_flag <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                        if (!cpu_done) begin
                            armed <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rd_ready) begin
                        if (cnt == RD_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + 9'd1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state; only the write strobe and the final-beat
    // pulse look at the handshake inputs directly.
    always_comb begin
        ld_ready   = 1'b0;
        mem_sel    = 1'b1;
        mem_wr_en  = 1'b0;
        mem_addr   = 8'd0;
        mem_wr_dat = 8'd0;
        cpu_req    = 1'b0;
        rd_valid   = 1'b0;
        rd_data    = 8'd0;
        job_done   = 1'b0;
        case (state)
            S_LOAD: begin
                ld_ready   = 1'b1;
                mem_wr_en  = ld_valid;
                mem_addr   = ld_addr;
                mem_wr_dat = ld_data;
            end
            S_REQ: begin
                mem_sel = 1'b0;
                cpu_req = 1'b1;
            end
            S_RUN: begin
                mem_sel = 1'b0;
            end
            S_DRAIN: begin
                mem_addr = rd_addr;
                rd_valid = 1'b1;
                rd_data  = mem_rd_dat;
                job_done = rd_ready && (cnt == RD_LAST);
            end
            default: begin
            end
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign timeout_err = timeout_flag;

endmodule
